// File: rtl/sys_clkgen_pkg.sv
// Shared types and helpers for the system clock-enable generator.
//   state_e   : lock-qualification FSM states
//   cnt_width : width of a counter that must hold 0..n-1 (minimum 1 bit)
//   DIV_W_DEF : default width of the per-channel divide/phase fields
package sys_clkgen_pkg;

    localparam int unsigned DIV_W_DEF = 16;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        RUN       = 2'd2
    } state_e;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sub_top_sys_clken_ch.sv
// One clock-enable channel: stored divide (and optional phase), a period
// counter and a registered one-cycle enable.
// Optional feature macro: CLKEN_PHASE_EN (enable at counter==phase instead of 0).
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   run       : channel may count and emit enables this cycle
//   load      : store div/phase and restart the counter at 0
//   div       : divide ratio (0 behaves as 1)
//   phase     : enable position within the period
//   clk_en    : registered enable pulse
module sub_top_sys_clken_ch
    import sys_clkgen_pkg::*;
#(
    parameter int unsigned DIV_W   = DIV_W_DEF,
    parameter int unsigned DEF_DIV = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             load,
    input  logic [DIV_W-1:0] div,
    input  logic [DIV_W-1:0] phase,
    output logic             clk_en
);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] last_c;
    logic             en_q, en_d;
    logic             match_c;

`ifdef CLKEN_PHASE_EN
    logic [DIV_W-1:0] phase_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= '0;
        end else if (load) begin
            phase_q <= phase;
        end
    end

    assign match_c = (cnt_q == phase_q);
`else
    logic phase_unused;
    assign phase_unused = ^phase;
    assign match_c      = (cnt_q == '0);
`endif

    // Last counter value of a period; div 0 and 1 both collapse to a one-state period
    assign last_c = (div_q == '0) ? '0 : div_q - DIV_W'(1);

    // Counter is held at 0 outside run so every channel restarts aligned
    always_comb begin
        cnt_d = cnt_q;
        en_d  = 1'b0;
        if (load) begin
            cnt_d = '0;
        end else if (run) begin
            en_d  = match_c;
            cnt_d = (cnt_q == last_c) ? '0 : cnt_q + DIV_W'(1);
        end else begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= DIV_W'(DEF_DIV);
            cnt_q <= '0;
            en_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            en_q  <= en_d;
            if (load) begin
                div_q <= div;
            end
        end
    end

    assign clk_en = en_q;

endmodule

// File: rtl/sub_top_sys_clken_gen.sv
// System clock-enable generator: qualifies PLL lock, then emits NUM_CH
// programmable clock-enable streams plus locked / downstream reset.
// Optional feature macro: CLKEN_PHASE_EN (per-channel phase, phase>=div rejected).
// Ports:
//   refclk, rst          : PLL output clock, synchronous active-high reset
//   pll_locked           : raw asynchronous PLL lock
//   cfg_wr/ch/div/phase  : channel configuration write
//   cfg_ack, cfg_err     : write acknowledge / rejected-write pulse
//   clk_en               : per-channel enable pulses
//   locked, sys_rst      : high / low only while running
module sub_top_sys_clken_gen
    import sys_clkgen_pkg::*;
#(
    parameter  int unsigned NUM_CH      = 4,
    parameter  int unsigned DIV_W       = DIV_W_DEF,
    parameter  int unsigned LOCK_CYCLES = 1024,
    parameter  int unsigned DEF_DIV     = 1,
    localparam int unsigned CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              pll_locked,
    input  logic              cfg_wr,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic [DIV_W-1:0]  cfg_phase,
    output logic              cfg_ack,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] clk_en,
    output logic              locked,
    output logic              sys_rst
);

    localparam int unsigned LCNT_W = cnt_width(LOCK_CYCLES);

    logic              sync1_q, sync2_q;
    state_e            state_q, state_d;
    logic [LCNT_W-1:0] lcnt_q, lcnt_d;
    logic              locked_q, sys_rst_q;
    logic              ack_q, err_q;
    logic              cfg_bad_c;
    logic              run_c;
    logic [NUM_CH-1:0] load_c;

    // Two-flop synchroniser for the asynchronous lock flag
    always_ff @(posedge refclk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= pll_locked;
            sync2_q <= sync1_q;
        end
    end

    // Lock qualification: LOCK_CYCLES consecutive synced-lock cycles before RUN
    always_comb begin
        state_d = state_q;
        lcnt_d  = lcnt_q;
        unique case (state_q)
            WAIT_LOCK: begin
                lcnt_d = '0;
                if (sync2_q) begin
                    state_d = STABLE;
                end
            end
            STABLE: begin
                if (!sync2_q) begin
                    state_d = WAIT_LOCK;
                    lcnt_d  = '0;
                end else if (lcnt_q == LCNT_W'(LOCK_CYCLES - 1)) begin
                    state_d = RUN;
                    lcnt_d  = '0;
                end else begin
                    lcnt_d = lcnt_q + LCNT_W'(1);
                end
            end
            RUN: begin
                lcnt_d = '0;
                if (!sync2_q) begin
                    state_d = WAIT_LOCK;
                end
            end
            default: begin
                state_d = WAIT_LOCK;
                lcnt_d  = '0;
            end
        endcase
    end

    // Outputs follow the next state so they change on the same edge as the FSM
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q   <= WAIT_LOCK;
            lcnt_q    <= '0;
            locked_q  <= 1'b0;
            sys_rst_q <= 1'b1;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            lcnt_q    <= lcnt_d;
            locked_q  <= (state_d == RUN);
            sys_rst_q <= (state_d != RUN);
            ack_q     <= cfg_wr;
            err_q     <= cfg_wr && cfg_bad_c;
        end
    end

    // Write decode; a rejected write touches no channel
`ifdef CLKEN_PHASE_EN
    logic [DIV_W-1:0] div_eff_c;
    assign div_eff_c = (cfg_div == '0) ? DIV_W'(1) : cfg_div;
    assign cfg_bad_c = (32'(cfg_ch) >= NUM_CH) || (cfg_phase >= div_eff_c);
`else
    assign cfg_bad_c = (32'(cfg_ch) >= NUM_CH);
`endif

    // Channels count only while RUN persists, so a lock drop silences them on the exit edge
    assign run_c = (state_q == RUN) && sync2_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign load_c[i] = cfg_wr && !cfg_bad_c && (32'(cfg_ch) == 32'(i));

        sub_top_sys_clken_ch #(
            .DIV_W   (DIV_W),
            .DEF_DIV (DEF_DIV)
        ) u_ch (
            .clk    (refclk),
            .rst    (rst),
            .run    (run_c),
            .load   (load_c[i]),
            .div    (cfg_div),
            .phase  (cfg_phase),
            .clk_en (clk_en[i])
        );
    end

    assign cfg_ack = ack_q;
    assign cfg_err = err_q;
    assign locked  = locked_q;
    assign sys_rst = sys_rst_q;

endmodule

// File: tb/tb_sub_top_sys_clken_gen.sv
// Self-checking bench for sub_top_sys_clken_gen (NUM_CH=3, LOCK_CYCLES=16).
module tb_sub_top_sys_clken_gen;

    localparam int unsigned NUM_CH  = 3;
    localparam int unsigned DIV_W   = 8;
    localparam int unsigned LC      = 16;
    localparam int unsigned DEF_DIV = 1;
    localparam int unsigned CH_W    = 2;
    localparam int unsigned VW      = NUM_CH + 4;
`ifdef CLKEN_PHASE_EN
    localparam bit PHASE_ON = 1'b1;
`else
    localparam bit PHASE_ON = 1'b0;
`endif

    logic              refclk     = 1'b0;
    logic              rst        = 1'b1;
    logic              pll_locked = 1'b0;
    logic              cfg_wr     = 1'b0;
    logic [CH_W-1:0]   cfg_ch     = '0;
    logic [DIV_W-1:0]  cfg_div    = '0;
    logic [DIV_W-1:0]  cfg_phase  = '0;
    logic              cfg_ack, cfg_err, locked, sys_rst;
    logic [NUM_CH-1:0] clk_en;

    int total = 0;
    int bad   = 0;

    sub_top_sys_clken_gen #(
        .NUM_CH      (NUM_CH),
        .DIV_W       (DIV_W),
        .LOCK_CYCLES (LC),
        .DEF_DIV     (DEF_DIV)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .cfg_wr     (cfg_wr),
        .cfg_ch     (cfg_ch),
        .cfg_div    (cfg_div),
        .cfg_phase  (cfg_phase),
        .cfg_ack    (cfg_ack),
        .cfg_err    (cfg_err),
        .clk_en     (clk_en),
        .locked     (locked),
        .sys_rst    (sys_rst)
    );

    always #5 refclk = ~refclk;

    // ---------------- reference model ----------------
    // locked after an edge <=> pll_locked (seen two edges late) has been high for LC+1
    // consecutive edges; a channel pulses when its run-edges-since-restart mod div == phase.
    bit                p_d1 = 0, p_d2 = 0;
    int                run_len = 0;
    bit                m_locked = 0, m_ack = 0, m_err = 0;
    logic [NUM_CH-1:0] m_en = '0;
    int                m_div[NUM_CH];
    int                m_ph[NUM_CH];
    int                m_k[NUM_CH];
    bit                ls, prev_lk, m_run, badw;
    int                deff;

    always @(posedge refclk) begin
        if (rst) begin
            p_d1 = 0; p_d2 = 0; run_len = 0;
            m_locked = 0; m_ack = 0; m_err = 0; m_en = '0;
            for (int i = 0; i < NUM_CH; i++) begin
                m_div[i] = DEF_DIV; m_ph[i] = 0; m_k[i] = 0;
            end
        end else begin
            ls   = p_d2;
            p_d2 = p_d1;
            p_d1 = pll_locked;
            run_len  = ls ? run_len + 1 : 0;
            prev_lk  = m_locked;
            m_locked = (run_len >= LC + 1);
            m_run    = prev_lk && m_locked;
            deff = (int'(cfg_div) == 0) ? 1 : int'(cfg_div);
            badw = (int'(cfg_ch) >= NUM_CH) || (PHASE_ON && int'(cfg_phase) >= deff);
            m_ack = cfg_wr;
            m_err = cfg_wr && badw;
            for (int i = 0; i < NUM_CH; i++) begin
                if (cfg_wr && !badw && int'(cfg_ch) == i) begin
                    m_div[i] = int'(cfg_div);
                    m_ph[i]  = PHASE_ON ? int'(cfg_phase) : 0;
                    m_k[i]   = 0;
                    m_en[i]  = 1'b0;
                end else if (m_run) begin
                    deff    = (m_div[i] == 0) ? 1 : m_div[i];
                    m_en[i] = ((m_k[i] % deff) == m_ph[i]);
                    m_k[i]  = m_k[i] + 1;
                end else begin
                    m_k[i]  = 0;
                    m_en[i] = 1'b0;
                end
            end
        end
    end

    function automatic logic [VW-1:0] exp_vec();
        return {m_ack, m_err, m_en, m_locked, !m_locked};
    endfunction

    function automatic logic [VW-1:0] act_vec();
        return {cfg_ack, cfg_err, clk_en, locked, sys_rst};
    endfunction

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic apply_reset();
        @(negedge refclk);
        rst    = 1'b1;
        cfg_wr = 1'b0;
        repeat (3) @(negedge refclk);
        rst = 1'b0;
    endtask

    task automatic cfg_write(input int ch, input int dv, input int ph);
        cfg_wr    = 1'b1;
        cfg_ch    = CH_W'(ch);
        cfg_div   = DIV_W'(dv);
        cfg_phase = DIV_W'(ph);
        @(negedge refclk);
        cfg_wr = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [VW-1:0] a, e;
        pll_locked = 1'b0;
        @(negedge refclk);
        rst = 1'b1; cfg_wr = 1'b1; cfg_ch = '0; cfg_div = 8'd5; cfg_phase = '0;
        repeat (3) @(negedge refclk);
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL reset_locked got=%b exp=0", locked); end
        total++; if (sys_rst !== 1'b1) begin bad++; $display("FAIL reset_sys_rst got=%b exp=1", sys_rst); end
        total++; if (clk_en !== '0) begin bad++; $display("FAIL reset_clk_en got=%b exp=0", clk_en); end
        total++; if ({cfg_ack, cfg_err} !== 2'b00) begin bad++; $display("FAIL reset_ack_err got=%b exp=00", {cfg_ack, cfg_err}); end
        cfg_wr = 1'b0; rst = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge refclk);
            a = act_vec(); e = exp_vec();
            total++; if (a !== e) begin bad++; $display("FAIL reset_idle cyc=%0d got=%b exp=%b", c, a, e); end
        end
    endtask

    task automatic test_lock_latency();
        logic [VW-1:0] a, e;
        int rise = -1;
        pll_locked = 1'b1;
        apply_reset();
        for (int c = 1; c <= 40; c++) begin
            @(negedge refclk);
            a = act_vec(); e = exp_vec();
            total++; if (a !== e) begin bad++; $display("FAIL lock_latency cyc=%0d got=%b exp=%b", c, a, e); end
            if (locked === 1'b1 && rise < 0) rise = c;
        end
        total++; if (rise != 19) begin bad++; $display("FAIL lock_latency_rise got=%0d exp=19", rise); end
    endtask

    task automatic test_lock_glitch();
        logic [VW-1:0] a, e;
        int rise = -1;
        pll_locked = 1'b1;
        apply_reset();
        for (int c = 1; c <= 50; c++) begin
            @(negedge refclk);
            a = act_vec(); e = exp_vec();
            total++; if (a !== e) begin bad++; $display("FAIL lock_glitch cyc=%0d got=%b exp=%b", c, a, e); end
            if (locked === 1'b1 && rise < 0) rise = c;
            if (c == 11) pll_locked = 1'b0;
            if (c == 12) pll_locked = 1'b1;
        end
        total++; if (rise != 31) begin bad++; $display("FAIL lock_glitch_rise got=%0d exp=31", rise); end
    endtask

    task automatic test_divide();
        logic [VW-1:0] a, e;
        int t0[2], t1[2], n[2];
        logic [NUM_CH-1:0] first_vec = '0;
        n[0] = 0; n[1] = 0; t0[0] = 0; t0[1] = 0; t1[0] = 0; t1[1] = 0;
        pll_locked = 1'b0;
        apply_reset();
        cfg_write(0, 4, 0);
        cfg_write(1, 3, 0);
        pll_locked = 1'b1;
        for (int c = 1; c <= 50; c++) begin
            @(negedge refclk);
            a = act_vec(); e = exp_vec();
            total++; if (a !== e) begin bad++; $display("FAIL divide cyc=%0d got=%b exp=%b", c, a, e); end
            if (first_vec == '0) first_vec = clk_en;
            for (int i = 0; i < 2; i++) begin
                if (clk_en[i] === 1'b1) begin
                    if (n[i] == 0) t0[i] = c;
                    if (n[i] == 1) t1[i] = c;
                    n[i]++;
                end
            end
        end
        total++; if (first_vec !== 3'b111) begin bad++; $display("FAIL divide_aligned got=%b exp=111", first_vec); end
        total++; if (t1[0] - t0[0] != 4) begin bad++; $display("FAIL divide_period0 got=%0d exp=4", t1[0] - t0[0]); end
        total++; if (t1[1] - t0[1] != 3) begin bad++; $display("FAIL divide_period1 got=%0d exp=3", t1[1] - t0[1]); end
    endtask

    task automatic test_lock_loss();
        logic [VW-1:0] a, e;
        logic [NUM_CH-1:0] first_vec = '0;
        pll_locked = 1'b0;
        cfg_write(2, 2, 0);
        for (int c = 1; c <= 2; c++) begin
            @(negedge refclk);
            a = act_vec(); e = exp_vec();
            total++; if (a !== e) begin bad++; $display("FAIL lock_loss cyc=%0d got=%b exp=%b", c, a, e); end
        end
        total++; if ({locked, sys_rst, clk_en} !== {1'b0, 1'b1, 3'b000})
            begin bad++; $display("FAIL lock_loss_outputs got=%b exp=01000", {locked, sys_rst, clk_en}); end
        pll_locked = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge refclk);
            a = act_vec(); e = exp_vec();
            total++; if (a !== e) begin bad++; $display("FAIL relock cyc=%0d got=%b exp=%b", c, a, e); end
            if (first_vec == '0) first_vec = clk_en;
        end
        total++; if (first_vec !== 3'b111) begin bad++; $display("FAIL relock_aligned got=%b exp=111", first_vec); end
    endtask

    task automatic test_cfg_err();
        logic [VW-1:0] a, e;
        cfg_wr = 1'b1; cfg_ch = 2'd3; cfg_div = 8'd7; cfg_phase = '0;
        @(negedge refclk);
        cfg_wr = 1'b0;
        total++; if ({cfg_ack, cfg_err} !== 2'b11) begin bad++; $display("FAIL cfg_err_badch got=%b exp=11", {cfg_ack, cfg_err}); end
`ifdef CLKEN_PHASE_EN
        cfg_wr = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd4; cfg_phase = 8'd5;
        @(negedge refclk);
        cfg_wr = 1'b0;
        total++; if ({cfg_ack, cfg_err} !== 2'b11) begin bad++; $display("FAIL cfg_err_phase got=%b exp=11", {cfg_ack, cfg_err}); end
`endif
        cfg_wr = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd5; cfg_phase = '0;
        @(negedge refclk);
        cfg_wr = 1'b0;
        total++; if ({cfg_ack, cfg_err} !== 2'b10) begin bad++; $display("FAIL cfg_ok got=%b exp=10", {cfg_ack, cfg_err}); end
        for (int c = 1; c <= 20; c++) begin
            @(negedge refclk);
            a = act_vec(); e = exp_vec();
            total++; if (a !== e) begin bad++; $display("FAIL cfg_err_timing cyc=%0d got=%b exp=%b", c, a, e); end
        end
    endtask

    task automatic test_back_to_back();
        logic [VW-1:0] a, e;
        int chs[4] = '{0, 0, 1, 2};
        int dvs[4] = '{2, 6, 5, 0};
        for (int w = 0; w < 4; w++) begin
            cfg_wr = 1'b1; cfg_ch = CH_W'(chs[w]); cfg_div = DIV_W'(dvs[w]); cfg_phase = '0;
            @(negedge refclk);
            a = act_vec(); e = exp_vec();
            total++; if (a !== e) begin bad++; $display("FAIL b2b_write w=%0d got=%b exp=%b", w, a, e); end
        end
        cfg_wr = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge refclk);
            a = act_vec(); e = exp_vec();
            total++; if (a !== e) begin bad++; $display("FAIL b2b_run cyc=%0d got=%b exp=%b", c, a, e); end
        end
    endtask

`ifdef CLKEN_PHASE_EN
    task automatic test_phase();
        logic [VW-1:0] a, e;
        int f0 = -1, f2 = -1, s2 = -1;
        pll_locked = 1'b0;
        apply_reset();
        cfg_write(0, 8, 0);
        cfg_write(2, 8, 3);
        pll_locked = 1'b1;
        for (int c = 1; c <= 50; c++) begin
            @(negedge refclk);
            a = act_vec(); e = exp_vec();
            total++; if (a !== e) begin bad++; $display("FAIL phase cyc=%0d got=%b exp=%b", c, a, e); end
            if (clk_en[0] === 1'b1 && f0 < 0) f0 = c;
            if (clk_en[2] === 1'b1) begin
                if (f2 >= 0 && s2 < 0) s2 = c;
                if (f2 < 0) f2 = c;
            end
        end
        total++; if (f2 - f0 != 3) begin bad++; $display("FAIL phase_offset got=%0d exp=3", f2 - f0); end
        total++; if (s2 - f2 != 8) begin bad++; $display("FAIL phase_period got=%0d exp=8", s2 - f2); end
    endtask
`endif

    task automatic test_random();
        logic [VW-1:0] a, e;
        pll_locked = 1'b1;
        for (int c = 1; c <= 800; c++) begin
            @(negedge refclk);
            a = act_vec(); e = exp_vec();
            total++; if (a !== e) begin bad++; $display("FAIL random cyc=%0d got=%b exp=%b", c, a, e); end
            rst       = ($urandom % 300 == 0);
            cfg_wr    = ($urandom % 4 == 0);
            cfg_ch    = CH_W'($urandom % 4);
            cfg_div   = DIV_W'($urandom % 10);
            cfg_phase = DIV_W'($urandom % 10);
            if ($urandom % 90 == 0) pll_locked = ~pll_locked;
            else if (!pll_locked && ($urandom % 8 == 0)) pll_locked = 1'b1;
        end
        rst = 1'b0; cfg_wr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_lock_latency();
        test_lock_glitch();
        test_divide();
        test_lock_loss();
        test_cfg_err();
        test_back_to_back();
`ifdef CLKEN_PHASE_EN
        test_phase();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
